// File: rtl/imem_ctrl.sv
// Instruction-memory controller: owns the single-port instruction RAM, arbitrates
// it between fetch and the host port, and sequences the core through LOAD/RUN/HALT.
//   state | meaning
//   LOAD  | after reset; pipeline held in reset, host owns RAM for boot loading
//   RUN   | fetch owns RAM; host may steal a slot after MAX_WAIT cycles
//   HALT  | debug halt; fetch stalled, host owns RAM
module imem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run_req,
  input  logic              i_halt_req,
  output logic [1:0]        o_state,
  output logic              o_core_rst,
  input  logic [15:0]       i_fetch_pc,
  output logic              o_fetch_stall,
  output logic              o_fetch_valid,
  output logic [15:0]       o_fetch_instr,
  output logic              o_oob_err,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [15:0]       i_host_wdata,
  output logic              o_host_rvalid,
  output logic [15:0]       o_host_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic             r_fetch_pend;
  logic             r_oob_pend;
  logic             r_host_rd_pend;
  logic             r_oob_err;

  logic             w_in_run;
  logic             w_grant;
  logic             w_host_acc;
  logic             w_oob;
  logic             w_fetch_issue;
  logic             w_oob_issue;
  logic             w_boot_exit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (i_run_req)                 w_state_nxt = ST_RUN;
      ST_RUN:  if (i_halt_req)                w_state_nxt = ST_HALT;
      ST_HALT: if (i_run_req && !i_halt_req)  w_state_nxt = ST_RUN;
      default:                                w_state_nxt = ST_LOAD;
    endcase
  end

  // Arbitration and RAM steering always use the current state, never the next one.
  always_comb begin
    w_in_run      = 1'b0;
    w_grant       = 1'b0;
    w_host_acc    = 1'b0;
    w_oob         = 1'b0;
    w_fetch_issue = 1'b0;
    w_oob_issue   = 1'b0;
    w_wait_nxt    = '0;
    w_boot_exit   = 1'b0;

    w_in_run      = (r_state == ST_RUN);
    w_grant       = w_in_run && i_host_valid && (r_wait_cnt == W_MAX);
    w_host_acc    = i_rst && i_host_valid && (!w_in_run || w_grant);
    w_oob         = (i_fetch_pc[15:ADDR_W+1] != '0) || i_fetch_pc[0];
    w_fetch_issue = i_rst && w_in_run && !w_grant && !w_oob;
    w_oob_issue   = i_rst && w_in_run && !w_grant && w_oob;
    w_boot_exit   = (r_state == ST_LOAD) && (w_state_nxt == ST_RUN);
    if (w_in_run && i_host_valid && !w_grant)
      w_wait_nxt = r_wait_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= ST_LOAD;
      r_wait_cnt     <= '0;
      r_fetch_pend   <= 1'b0;
      r_oob_pend     <= 1'b0;
      r_host_rd_pend <= 1'b0;
      r_oob_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wait_cnt     <= w_wait_nxt;
      r_fetch_pend   <= w_fetch_issue;
      r_oob_pend     <= w_oob_issue;
      r_host_rd_pend <= w_host_acc && !i_host_we;
      if (w_boot_exit)
        r_oob_err <= 1'b0;
      else if (w_oob_issue)
        r_oob_err <= 1'b1;
    end
  end

  assign o_state       = r_state;
  assign o_core_rst    = (r_state == ST_LOAD);
  assign o_fetch_stall = !w_in_run || w_grant;
  assign o_fetch_valid = r_fetch_pend || r_oob_pend;
  assign o_fetch_instr = r_fetch_pend ? i_mem_rdata : 16'h0000;
  assign o_oob_err     = r_oob_err;
  assign o_host_ready  = w_host_acc;
  assign o_host_rvalid = r_host_rd_pend;
  assign o_host_rdata  = r_host_rd_pend ? i_mem_rdata : 16'h0000;

  assign o_mem_en    = w_host_acc || w_fetch_issue;
  assign o_mem_we    = w_host_acc && i_host_we;
  assign o_mem_addr  = w_host_acc ? i_host_addr : i_fetch_pc[ADDR_W:1];
  assign o_mem_wdata = i_host_wdata;

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Instruction-memory controller and arbiter for the 16-bit pipeline. It owns the single-port synchronous instruction RAM and shares it between the fetch stage and a host/debug port. It sequences the core through boot loading, normal running and debug halt, and drives the pipeline's reset and fetch stall. It sits between the fetch stage, the instruction RAM and the host interface.

## Interface
- ADDR_W, 10, word-address width of instruction RAM (2^ADDR_W x 16)
- MAX_WAIT, 4, cycles a pending host request waits in RUN before stealing a fetch slot (0 = immediate)

- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- run_req  in  1  pulse: LOAD/HALT -> RUN
- halt_req  in  1  pulse: RUN -> HALT
- state  out  2  LOAD=00, RUN=01, HALT=10
- core_rst  out  1  active-high reset to pipeline stages
- fetch_pc  in  16  byte PC from fetch stage
- fetch_stall  out  1  fetch must hold PC this cycle
- fetch_valid  out  1  fetch_instr valid (for PC presented previous cycle)
- fetch_instr  out  16  instruction word
- oob_err  out  1  sticky: fetch_pc outside RAM or odd
- host_valid  in  1  host request; fields held until accepted
- host_ready  out  1  request accepted this cycle
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  word address
- host_wdata  in  16  write data
- host_rvalid  out  1  read data valid
- host_rdata  out  16  read data
- mem_en, mem_we  out  1  RAM enable/write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, valid one cycle after mem_en read

## Operation
- States: LOAD (after reset), RUN, HALT. Registered; transitions take effect the cycle after the request.
- LOAD -> RUN on run_req. RUN -> HALT on halt_req. HALT -> RUN on run_req. halt_req and run_req together: halt_req wins; in LOAD, halt_req is ignored.
- core_rst=1 only in LOAD. fetch_stall=1 in LOAD and HALT.
- LOAD/HALT: host owns RAM; host_ready = host_valid; RAM driven from the host port.
- RUN: fetch owns RAM each cycle; mem_addr = fetch_pc[ADDR_W:1], mem_en=1, mem_we=0.
- RUN host arbitration: wait_cnt increments each cycle host_valid=1 and not granted.
  - Grant when wait_cnt == MAX_WAIT: host_ready=1, fetch_stall=1, RAM driven by the host, wait_cnt cleared.
  - No fetch read is issued in a stolen cycle.
- Host read: host_rvalid=1 and host_rdata=mem_rdata in the cycle after acceptance. Host write completes in the accept cycle.
- Fetch read: fetch_valid=1 with fetch_instr=mem_rdata in the cycle after a fetch read.
  - Otherwise fetch_valid=0 and fetch_instr=16'h0000.
- Out-of-bounds PC: fetch_pc[15:ADDR_W+1] != 0 or fetch_pc[0]=1.
  - Response: no RAM access; next cycle fetch_valid=1, fetch_instr=16'h0000; oob_err set.
  - oob_err is cleared only by reset or a LOAD->RUN transition.

## Timing
- Reset (rst=0 at clk edge): state=LOAD, core_rst=1, fetch_stall=1, fetch_valid=0, fetch_instr=0, host_ready=0, host_rvalid=0, host_rdata=0, oob_err=0, wait_cnt=0, mem_en=0.
- While rst=0, host_ready and mem_en are forced 0.
- Reset mid-operation aborts any pending host request; no write occurs in the reset cycle.
- Fetch latency: 1 cycle PC -> instruction. Host latency: accept -> rdata 1 cycle.
- Entering HALT: a fetch read issued in the last RUN cycle still returns fetch_valid next cycle.
- Leaving LOAD/HALT: a host read accepted in the last cycle still returns host_rvalid.
- Request in the same cycle as a state change: arbitration uses the current (pre-transition) state.
- host_valid dropped before acceptance: wait_cnt clears.
- Worst-case host wait in RUN: MAX_WAIT+1 cycles, so fetch bandwidth is at least MAX_WAIT/(MAX_WAIT+1).

## Test plan
- Reset, then in LOAD write 16'h1234 to addr 0 and 16'hABCD to addr 1 -> host_ready same cycle; core_rst=1, fetch_stall=1; readback returns those values with host_rvalid 1 cycle later.
- run_req; fetch_pc=0 then 2 -> state=RUN, core_rst=0; fetch_instr=16'h1234 then 16'hABCD, each 1 cycle after the PC.
- In RUN with MAX_WAIT=4, host read held from cycle t -> host_ready and fetch_stall at t+4, fetch_valid=0 at t+5, host_rvalid at t+5.
- halt_req and run_req in the same cycle in RUN -> state=HALT; in HALT a host write is accepted immediately; run_req -> RUN; fetch resumes.
- fetch_pc=16'h0801 (ADDR_W=10) -> no mem_en; fetch_instr=0; oob_err=1 and sticky until the next LOAD->RUN transition.
- rst=0 asserted during a host write wait in RUN -> no write reaches RAM; all outputs take their reset values at the next edge.
